// File: rtl/noc_flit_pkg.sv
// -----------------------------------------------------------------------------
// noc_flit_pkg
// Shared definitions for the NoC ejection-side packet receiver.
//   - Bit positions of the fields inside a 32-bit head flit
//   - Widths of the node id and length fields
//   - Receiver FSM state encoding
//   - Small helpers that pull the fields out of a head flit
// No ports (package).
// -----------------------------------------------------------------------------
package noc_flit_pkg;

    // Head flit layout: [31:28] dest, [27:24] src, [23:16] len, [15:0] ignored
    localparam int HEAD_DEST_MSB = 31;
    localparam int HEAD_DEST_LSB = 28;
    localparam int HEAD_SRC_MSB  = 27;
    localparam int HEAD_SRC_LSB  = 24;
    localparam int HEAD_LEN_MSB  = 23;
    localparam int HEAD_LEN_LSB  = 16;

    localparam int NODE_ID_W = 4;
    localparam int LEN_W     = 8;

    // FIFO entry = {sop, eop, src, data}; width depends on the flit width
    function automatic int entry_width(input int data_width);
        return 2 + NODE_ID_W + data_width;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } rx_state_e;

    function automatic logic [NODE_ID_W-1:0] head_dest(input logic [31:0] flit);
        return flit[HEAD_DEST_MSB:HEAD_DEST_LSB];
    endfunction

    function automatic logic [NODE_ID_W-1:0] head_src(input logic [31:0] flit);
        return flit[HEAD_SRC_MSB:HEAD_SRC_LSB];
    endfunction

    function automatic logic [LEN_W-1:0] head_len(input logic [31:0] flit);
        return flit[HEAD_LEN_MSB:HEAD_LEN_LSB];
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock first-word-fall-through FIFO. The word at the head of the queue
// is presented on rd_data_o whenever empty_o is low; a pop advances to the next
// word. Storage is a plain array so it maps onto distributed RAM. Full and empty
// are registered flags derived from an occupancy counter.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (empties the FIFO)
//   wr_en_i    in   push request (ignored while full)
//   wr_data_i  in   WIDTH   word to push
//   rd_en_i    in   pop request (ignored while empty)
//   rd_data_o  out  WIDTH   head-of-queue word
//   full_o     out  registered full flag
//   empty_o    out  registered empty flag
// DEPTH must be a power of two, >= 2 (pointers wrap naturally).
// -----------------------------------------------------------------------------
module noc_sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;

    logic do_push;
    logic do_pop;

    // A push while full is refused; a simultaneous pop still happens.
    assign do_push = wr_en_i && !full_q;
    assign do_pop  = rd_en_i && !empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;   // idle, or push+pop leaves occupancy unchanged
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/noc_packet_receiver.sv
// -----------------------------------------------------------------------------
// noc_packet_receiver
// Ejection endpoint of one NoC node. Accepts the flit stream from the router,
// decodes the head flit, forwards the payload flits through a FIFO to the local
// core framed with sop/eop and the source id, drops packets addressed to other
// nodes, flags malformed heads and counts delivered packets.
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   data_in        in   DATA_WIDTH  flit from the router
//   valid_in       in   flit valid
//   ready_in       out  flit accepted when valid_in && ready_in
//   pkt_data_out   out  DATA_WIDTH  payload word to the core
//   pkt_src_out    out  4   source node of the current packet
//   pkt_sop_out    out  first payload word of a packet
//   pkt_eop_out    out  last payload word of a packet
//   pkt_valid_out  out  payload word valid
//   pkt_ready_out  in   core accepts the word when valid && ready
//   err_dest_out   out  one-cycle pulse: head addressed to another node
//   err_len_out    out  one-cycle pulse: head with zero length
//   pkt_count_out  out  16  packets fully delivered, wrapping
// -----------------------------------------------------------------------------
module noc_packet_receiver
    import noc_flit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NODE_ID    = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pkt_data_out,
    output logic [NODE_ID_W-1:0]  pkt_src_out,
    output logic                  pkt_sop_out,
    output logic                  pkt_eop_out,
    output logic                  pkt_valid_out,
    input  logic                  pkt_ready_out,
    output logic                  err_dest_out,
    output logic                  err_len_out,
    output logic [15:0]           pkt_count_out
);

    localparam int                   ENTRY_W = entry_width(DATA_WIDTH);
    localparam logic [NODE_ID_W-1:0] MY_ID   = NODE_ID_W'(NODE_ID);
    localparam logic [LEN_W-1:0]     CNT_ONE = LEN_W'(1);

    rx_state_e            state_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [NODE_ID_W-1:0] src_q;
    logic                 first_q;
    logic                 err_dest_q;
    logic                 err_len_q;
    logic [15:0]          pkt_count_q;

    logic                 flit_acc;
    logic                 last_flit;
    logic [NODE_ID_W-1:0] hd_dest;
    logic [NODE_ID_W-1:0] hd_src;
    logic [LEN_W-1:0]     hd_len;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_wr_entry;
    logic [ENTRY_W-1:0]   fifo_rd_entry;

    // ------------------------------------------------------------------
    // Flow control toward the router: a function of state and the
    // registered full flag only, so no combinational path crosses the block.
    // ------------------------------------------------------------------
    always_comb begin
        ready_in = 1'b0;
        unique case (state_q)
            ST_IDLE:    ready_in = 1'b1;
            ST_PAYLOAD: ready_in = !fifo_full;
            ST_DROP:    ready_in = 1'b1;
            default:    ready_in = 1'b0;
        endcase
    end

    assign flit_acc  = valid_in && ready_in;
    assign last_flit = (cnt_q == CNT_ONE);

    assign hd_dest = head_dest(data_in[31:0]);
    assign hd_src  = head_src(data_in[31:0]);
    assign hd_len  = head_len(data_in[31:0]);

    // ------------------------------------------------------------------
    // Payload buffer
    // ------------------------------------------------------------------
    assign fifo_push     = flit_acc && (state_q == ST_PAYLOAD);
    assign fifo_wr_entry = {first_q, last_flit, src_q, data_in};
    assign fifo_pop      = !fifo_empty && pkt_ready_out;

    noc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_push),
        .wr_data_i (fifo_wr_entry),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // The storage array is not reset, so mask the word while nothing is
    // buffered; this keeps the core-side outputs at zero out of reset.
    assign {pkt_sop_out, pkt_eop_out, pkt_src_out, pkt_data_out} =
        fifo_empty ? '0 : fifo_rd_entry;
    assign pkt_valid_out = !fifo_empty;

    // ------------------------------------------------------------------
    // Receive FSM, error pulses and delivered-packet counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            first_q     <= 1'b0;
            err_dest_q  <= 1'b0;
            err_len_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            err_dest_q <= 1'b0;
            err_len_q  <= 1'b0;

            // Counted on the eop handshake at the core side, not on receipt.
            if (fifo_pop && fifo_rd_entry[ENTRY_W-2]) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (flit_acc) begin
                        // A zero length wins over a wrong destination: there
                        // is nothing to drop, so the next flit is a new head.
                        if (hd_len == '0) begin
                            err_len_q <= 1'b1;
                        end else if (hd_dest != MY_ID) begin
                            err_dest_q <= 1'b1;
                            cnt_q      <= hd_len;
                            state_q    <= ST_DROP;
                        end else begin
                            src_q   <= hd_src;
                            cnt_q   <= hd_len;
                            first_q <= 1'b1;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (flit_acc) begin
                        first_q <= 1'b0;
                        cnt_q   <= cnt_q - CNT_ONE;
                        if (last_flit) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (flit_acc) begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (last_flit) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign err_dest_out  = err_dest_q;
    assign err_len_out   = err_len_q;
    assign pkt_count_out = pkt_count_q;

endmodule
